// File: rtl/fp_transfer_pipe.sv
// fp_transfer_pipe
// Two-stage pipelined FP transfer / classify / sign-injection unit for the
// FPU issue path. Handles FMV.X.W/D, FMV.W/D.X, FCLASS.S/D and
// FSGNJ/FSGNJN/FSGNJX.S/D with RISC-V NaN-boxing of single-precision values.
// Stage 1 registers the NaN-box-checked operands, the FCLASS mask and the
// legality decision; stage 2 forms the result and holds it on the output
// until the consumer takes it. An opaque tag travels alongside each op.
module fp_transfer_pipe #(
    parameter int FLEN  = 64,
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    localparam int W    = (FLEN > XLEN) ? FLEN : XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_sp_dp,
    input  logic [W-1:0]     in_a,
    input  logic [FLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_to_int,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Operation encodings; 110 and 111 are reserved and reported as illegal.
    localparam logic [2:0] OP_MOV_INT_FP = 3'b000;
    localparam logic [2:0] OP_MOV_FP_INT = 3'b001;
    localparam logic [2:0] OP_FSGNJ      = 3'b010;
    localparam logic [2:0] OP_FSGNJN     = 3'b011;
    localparam logic [2:0] OP_FCLASS     = 3'b100;
    localparam logic [2:0] OP_FSGNJX     = 3'b101;

    // Canonical single-precision quiet NaN, already NaN-boxed.
    localparam logic [63:0] CANON_QNAN_SP = 64'hFFFF_FFFF_7FC0_0000;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // One-hot FCLASS mask of an SP (low 32 bits) or DP value.
    function automatic logic [9:0] fclass(input logic [63:0] v, input logic dp);
        logic sign;
        logic exp_max;
        logic exp_zero;
        logic man_zero;
        logic quiet;
        logic [9:0] mask;
        if (dp) begin
            sign     = v[63];
            exp_max  = &v[62:52];
            exp_zero = ~|v[62:52];
            man_zero = ~|v[51:0];
            quiet    = v[51];
        end else begin
            sign     = v[31];
            exp_max  = &v[30:23];
            exp_zero = ~|v[30:23];
            man_zero = ~|v[22:0];
            quiet    = v[22];
        end
        mask = 10'b0;
        if (exp_max) begin
            if (man_zero) begin
                if (sign) mask[0] = 1'b1;
                else      mask[7] = 1'b1;
            end else if (quiet) begin
                mask[9] = 1'b1;
            end else begin
                mask[8] = 1'b1;
            end
        end else if (exp_zero) begin
            if (man_zero) begin
                if (sign) mask[3] = 1'b1;
                else      mask[4] = 1'b1;
            end else begin
                if (sign) mask[2] = 1'b1;
                else      mask[5] = 1'b1;
            end
        end else begin
            if (sign) mask[1] = 1'b1;
            else      mask[6] = 1'b1;
        end
        return mask;
    endfunction

    // Place a 32-bit SP value in an FP register image, NaN-boxed to FLEN.
    function automatic logic [63:0] box_sp(input logic [31:0] x);
        logic [63:0] r;
        if (FLEN == 64) r = {32'hFFFF_FFFF, x};
        else            r = {32'h0000_0000, x};
        return r;
    endfunction

    // Place a 32-bit value in an integer register image, sign-extended to XLEN.
    function automatic logic [63:0] sext_xlen(input logic [31:0] x);
        logic [63:0] r;
        if (XLEN == 64) r = {{32{x[31]}}, x};
        else            r = {32'h0000_0000, x};
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s2_advance;

    // The output stage moves whenever it is empty or being drained, and the
    // input stage can take a new op whenever its content moves on. This
    // lets a full pipe refill without a bubble when the consumer resumes.
    assign s2_advance = !s2_valid_reg || out_ready;
    assign in_ready   = !s1_valid_reg || s2_advance;

    // ------------------------------------------------------------------
    // Stage 1 combinational: operand NaN-box check, classify, legality
    // ------------------------------------------------------------------
    logic [63:0] opnd_raw    [2];
    logic [63:0] opnd_fp     [2];
    logic        opnd_box_ok [2];

    assign opnd_raw[0] = 64'(in_a);
    assign opnd_raw[1] = 64'(in_b);

    // A single-precision FP operand is only meaningful when its upper half is
    // all ones; anything else reads as the canonical quiet NaN.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_nanbox
            assign opnd_box_ok[gi] = (FLEN != 64) || in_sp_dp || (&opnd_raw[gi][63:32]);
            assign opnd_fp[gi]     = opnd_box_ok[gi] ? opnd_raw[gi] : CANON_QNAN_SP;
        end
    endgenerate

    logic [9:0] in_class;
    logic       in_b_sign;
    logic       in_illegal;

    assign in_class  = fclass(opnd_fp[0], in_sp_dp);
    assign in_b_sign = in_sp_dp ? opnd_fp[1][63] : opnd_fp[1][31];

    // Unsupported opcode or a format this build cannot hold.
    always_comb begin
        in_illegal = 1'b0;
        if (in_op == 3'b110 || in_op == 3'b111) begin
            in_illegal = 1'b1;
        end
        if (in_sp_dp && (FLEN == 32)) begin
            in_illegal = 1'b1;
        end
        if (in_sp_dp && (XLEN == 32) &&
            (in_op == OP_MOV_INT_FP || in_op == OP_MOV_FP_INT)) begin
            in_illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [2:0]       s1_op_reg;
    logic             s1_dp_reg;
    logic             s1_illegal_reg;
    logic [63:0]      s1_a_raw_reg;
    logic [63:0]      s1_a_fp_reg;
    logic             s1_b_sign_reg;
    logic [9:0]       s1_class_reg;
    logic [TAG_W-1:0] s1_tag_reg;

    // Capture an offered op whenever stage 1 is free to accept; flush wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_op_reg      <= 3'b0;
            s1_dp_reg      <= 1'b0;
            s1_illegal_reg <= 1'b0;
            s1_a_raw_reg   <= 64'b0;
            s1_a_fp_reg    <= 64'b0;
            s1_b_sign_reg  <= 1'b0;
            s1_class_reg   <= 10'b0;
            s1_tag_reg     <= '0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_op_reg      <= in_op;
                s1_dp_reg      <= in_sp_dp;
                s1_illegal_reg <= in_illegal;
                s1_a_raw_reg   <= opnd_raw[0];
                s1_a_fp_reg    <= opnd_fp[0];
                s1_b_sign_reg  <= in_b_sign;
                s1_class_reg   <= in_class;
                s1_tag_reg     <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: result formation
    // ------------------------------------------------------------------
    logic        s1_a_sign;
    logic        inj_sign;
    logic [63:0] res_next;
    logic        to_int_next;

    assign s1_a_sign = s1_dp_reg ? s1_a_fp_reg[63] : s1_a_fp_reg[31];

    // Sign source for the three sign-injection flavours.
    always_comb begin
        inj_sign = s1_b_sign_reg;
        if (s1_op_reg == OP_FSGNJN) inj_sign = ~s1_b_sign_reg;
        if (s1_op_reg == OP_FSGNJX) inj_sign = s1_a_sign ^ s1_b_sign_reg;
    end

    // Build the result image and its destination file for the op in stage 1.
    always_comb begin
        res_next    = 64'b0;
        to_int_next = 1'b0;
        if (!s1_illegal_reg) begin
            case (s1_op_reg)
                OP_MOV_INT_FP: begin
                    res_next = s1_dp_reg ? s1_a_raw_reg : box_sp(s1_a_raw_reg[31:0]);
                end
                OP_MOV_FP_INT: begin
                    // Raw bits move across; a bad NaN-box is not substituted here.
                    res_next    = s1_dp_reg ? s1_a_raw_reg : sext_xlen(s1_a_raw_reg[31:0]);
                    to_int_next = 1'b1;
                end
                OP_FCLASS: begin
                    res_next    = {54'b0, s1_class_reg};
                    to_int_next = 1'b1;
                end
                OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
                    res_next = s1_dp_reg ? {inj_sign, s1_a_fp_reg[62:0]}
                                         : box_sp({inj_sign, s1_a_fp_reg[30:0]});
                end
                default: begin
                    res_next    = 64'b0;
                    to_int_next = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 / output registers
    // ------------------------------------------------------------------
    logic [W-1:0]     out_data_reg;
    logic             out_to_int_reg;
    logic             out_illegal_reg;
    logic [TAG_W-1:0] out_tag_reg;

    // Output only changes when it is empty or being consumed, so it stays
    // stable under back-pressure; flush drops whatever is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg    <= 1'b0;
            out_data_reg    <= '0;
            out_to_int_reg  <= 1'b0;
            out_illegal_reg <= 1'b0;
            out_tag_reg     <= '0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg    <= W'(res_next);
                out_to_int_reg  <= to_int_next;
                out_illegal_reg <= s1_illegal_reg;
                out_tag_reg     <= s1_tag_reg;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_data    = out_data_reg;
    assign out_to_int  = out_to_int_reg;
    assign out_illegal = out_illegal_reg;
    assign out_tag     = out_tag_reg;

endmodule

// File: tb/tb_fp_transfer_pipe.sv
// Testbench for fp_transfer_pipe: table-driven back-to-back vectors on a
// FLEN=64/XLEN=64 build, plus hand-written back-pressure, flush, reset and
// XLEN=32 sequences.
module tb_fp_transfer_pipe;

    localparam int TAG_W = 5;

    localparam logic [2:0] OP_MOV_INT_FP = 3'b000;
    localparam logic [2:0] OP_MOV_FP_INT = 3'b001;
    localparam logic [2:0] OP_FSGNJ      = 3'b010;
    localparam logic [2:0] OP_FSGNJN     = 3'b011;
    localparam logic [2:0] OP_FCLASS     = 3'b100;
    localparam logic [2:0] OP_FSGNJX     = 3'b101;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'b0;
    logic             in_sp_dp = 1'b0;
    logic [63:0]      in_a = 64'b0;
    logic [63:0]      in_b = 64'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [63:0]      out_data;
    logic             out_to_int;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    logic             in_ready32;
    logic             out_valid32;
    logic [63:0]      out_data32;
    logic             out_to_int32;
    logic             out_illegal32;
    logic [TAG_W-1:0] out_tag32;

    always #5 clk = ~clk;

    fp_transfer_pipe #(.FLEN(64), .XLEN(64), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sp_dp(in_sp_dp), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_to_int(out_to_int), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    fp_transfer_pipe #(.FLEN(64), .XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_op(in_op), .in_sp_dp(in_sp_dp), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
        .out_to_int(out_to_int32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    typedef struct {
        logic [2:0]  op;
        logic        dp;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_data;
        logic        exp_to_int;
        logic        exp_ill;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic [2:0] op, input logic dp,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] ex, input logic ti, input logic il);
        vec_t v;
        v.op = op; v.dp = dp; v.a = a; v.b = b;
        v.exp_data = ex; v.exp_to_int = ti; v.exp_ill = il;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic dp, input logic [63:0] a,
                         input logic [63:0] b, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_sp_dp = dp;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", out_data, 64'd0);
        check("rst out_to_int", 64'(out_to_int), 64'd0);
        check("rst out_illegal", 64'(out_illegal), 64'd0);
        check("rst out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 64'(in_ready), 64'd1);

        vecs[0]  = mk(OP_FCLASS, 1'b1, 64'hFFF0_0000_0000_0000, 64'h0, 64'h001, 1'b1, 1'b0);
        vecs[1]  = mk(OP_FCLASS, 1'b1, 64'h0000_0000_0000_0001, 64'h0, 64'h020, 1'b1, 1'b0);
        vecs[2]  = mk(OP_FCLASS, 1'b1, 64'h7FF8_0000_0000_0000, 64'h0, 64'h200, 1'b1, 1'b0);
        vecs[3]  = mk(OP_FCLASS, 1'b1, 64'h7FF0_0000_0000_0001, 64'h0, 64'h100, 1'b1, 1'b0);
        vecs[4]  = mk(OP_FCLASS, 1'b0, 64'h0000_0000_3F80_0000, 64'h0, 64'h200, 1'b1, 1'b0);
        vecs[5]  = mk(OP_FCLASS, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'h0, 64'h040, 1'b1, 1'b0);
        vecs[6]  = mk(OP_MOV_INT_FP, 1'b0, 64'h0000_0000_1234_5678, 64'h0, 64'hFFFF_FFFF_1234_5678, 1'b0, 1'b0);
        vecs[7]  = mk(OP_MOV_FP_INT, 1'b0, 64'hFFFF_FFFF_8000_0001, 64'h0, 64'hFFFF_FFFF_8000_0001, 1'b1, 1'b0);
        vecs[8]  = mk(OP_FSGNJX, 1'b1, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        vecs[9]  = mk(OP_FSGNJN, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 1'b0, 1'b0);
        vecs[10] = mk(OP_FSGNJ, 1'b1, 64'h3FF0_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 1'b0, 1'b0);
        vecs[11] = mk(OP_FSGNJ, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFC0_0000, 1'b0, 1'b0);
        vecs[12] = mk(OP_MOV_FP_INT, 1'b0, 64'h0000_0000_7FFF_FFFF, 64'h0, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0);
        vecs[13] = mk(OP_MOV_INT_FP, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        vecs[14] = mk(OP_FCLASS, 1'b1, 64'h8000_0000_0000_0000, 64'h0, 64'h008, 1'b1, 1'b0);
        vecs[15] = mk(OP_FCLASS, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h010, 1'b1, 1'b0);
        vecs[16] = mk(OP_FCLASS, 1'b0, 64'hFFFF_FFFF_807F_FFFF, 64'h0, 64'h004, 1'b1, 1'b0);
        vecs[17] = mk(OP_FCLASS, 1'b0, 64'hFFFF_FFFF_7F80_0000, 64'h0, 64'h080, 1'b1, 1'b0);
        vecs[18] = mk(OP_FCLASS, 1'b1, 64'hC000_0000_0000_0000, 64'h0, 64'h002, 1'b1, 1'b0);
        vecs[19] = mk(3'b111, 1'b1, 64'h3FF0_0000_0000_0000, 64'h0, 64'h0, 1'b0, 1'b1);
        vecs[20] = mk(3'b110, 1'b0, 64'hFFFF_FFFF_1234_5678, 64'h0, 64'h0, 1'b0, 1'b1);
        vecs[21] = mk(OP_FCLASS, 1'b0, 64'hFFFF_FFFF_7F80_0001, 64'h0, 64'h100, 1'b1, 1'b0);

        // Back-to-back issue, one result per cycle, 2-cycle latency
        out_ready = 1'b1;
        for (int c = 0; c <= NV; c++) begin
            int k;
            if (c < NV) begin
                drive(vecs[c].op, vecs[c].dp, vecs[c].a, vecs[c].b, 5'(c));
                check($sformatf("vec%0d in_ready", c), 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c == 0) begin
                check("latency out_valid after 1 cycle", 64'(out_valid), 64'd0);
            end else begin
                k = c - 1;
                check($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'd1);
                check($sformatf("vec%0d out_data", k), out_data, vecs[k].exp_data);
                check($sformatf("vec%0d out_to_int", k), 64'(out_to_int), 64'(vecs[k].exp_to_int));
                check($sformatf("vec%0d out_illegal", k), 64'(out_illegal), 64'(vecs[k].exp_ill));
                check($sformatf("vec%0d out_tag", k), 64'(out_tag), 64'(k));
                $display("vec %0d op %0d dp %0b a %h -> data %h to_int %0b illegal %0b tag %0d",
                         k, vecs[k].op, vecs[k].dp, vecs[k].a, out_data, out_to_int, out_illegal, out_tag);
            end
        end
        tick();
        check("drain out_valid", 64'(out_valid), 64'd0);

        // Back-pressure: three ops, consumer stalled for 5 cycles
        out_ready = 1'b0;
        drive(OP_MOV_INT_FP, 1'b1, 64'h1111_0000_0000_0010, 64'h0, 5'd16);
        check("bp accept0 in_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp s1 only out_valid", 64'(out_valid), 64'd0);
        drive(OP_MOV_INT_FP, 1'b1, 64'h1111_0000_0000_0011, 64'h0, 5'd17);
        check("bp accept1 in_ready", 64'(in_ready), 64'd1);
        tick();
        drive(OP_MOV_INT_FP, 1'b1, 64'h1111_0000_0000_0012, 64'h0, 5'd18);
        for (int h = 0; h < 5; h++) begin
            check($sformatf("bp hold%0d in_ready", h), 64'(in_ready), 64'd0);
            check($sformatf("bp hold%0d out_valid", h), 64'(out_valid), 64'd1);
            check($sformatf("bp hold%0d out_tag", h), 64'(out_tag), 64'd16);
            check($sformatf("bp hold%0d out_data", h), out_data, 64'h1111_0000_0000_0010);
            $display("bp hold %0d tag %0d data %h in_ready %0b", h, out_tag, out_data, in_ready);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp out1 valid", 64'(out_valid), 64'd1);
        check("bp out1 tag", 64'(out_tag), 64'd17);
        check("bp out1 data", out_data, 64'h1111_0000_0000_0011);
        $display("bp release tag %0d data %h", out_tag, out_data);
        tick();
        check("bp out2 valid", 64'(out_valid), 64'd1);
        check("bp out2 tag", 64'(out_tag), 64'd18);
        check("bp out2 data", out_data, 64'h1111_0000_0000_0012);
        $display("bp release tag %0d data %h", out_tag, out_data);
        tick();
        check("bp drained", 64'(out_valid), 64'd0);

        // Flush with both stages full and a new op accepted in the same cycle
        out_ready = 1'b0;
        drive(OP_FCLASS, 1'b1, 64'h0, 64'h0, 5'd20);
        tick();
        drive(OP_FCLASS, 1'b1, 64'h0, 64'h0, 5'd21);
        tick();
        check("flush pre out_valid", 64'(out_valid), 64'd1);
        check("flush pre out_tag", 64'(out_tag), 64'd20);
        out_ready = 1'b1;
        drive(OP_FCLASS, 1'b1, 64'h0, 64'h0, 5'd22);
        flush = 1'b1;
        #1;
        check("flush cycle in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'd0);
        $display("flush applied out_valid %0b", out_valid);
        tick();
        check("flush discard", 64'(out_valid), 64'd0);
        tick();
        check("flush empty", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(OP_MOV_INT_FP, 1'b1, 64'h2222_0000_0000_0024, 64'h0, 5'd24);
        tick();
        drive(OP_MOV_INT_FP, 1'b1, 64'h2222_0000_0000_0025, 64'h0, 5'd25);
        tick();
        in_valid = 1'b0;
        check("rst-mid pre out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst-mid out_valid", 64'(out_valid), 64'd0);
        check("rst-mid out_data", out_data, 64'd0);
        check("rst-mid out_tag", 64'(out_tag), 64'd0);
        check("rst-mid in_ready", 64'(in_ready), 64'd1);
        $display("rst mid-stream out_valid %0b data %h", out_valid, out_data);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("rst-mid after1", 64'(out_valid), 64'd0);
        tick();
        check("rst-mid after2", 64'(out_valid), 64'd0);

        // XLEN=32 build: DP move to integer is illegal, SP sign-extends to 32
        drive(OP_MOV_FP_INT, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd26);
        tick();
        drive(OP_MOV_FP_INT, 1'b0, 64'hFFFF_FFFF_8000_0001, 64'h0, 5'd27);
        tick();
        in_valid = 1'b0;
        check("x32 dp valid", 64'(out_valid32), 64'd1);
        check("x32 dp illegal", 64'(out_illegal32), 64'd1);
        check("x32 dp data", out_data32, 64'd0);
        check("x32 dp to_int", 64'(out_to_int32), 64'd0);
        check("x32 dp tag", 64'(out_tag32), 64'd26);
        check("x64 dp illegal", 64'(out_illegal), 64'd0);
        check("x64 dp data", out_data, 64'h0123_4567_89AB_CDEF);
        $display("x32 tag %0d data %h illegal %0b", out_tag32, out_data32, out_illegal32);
        tick();
        check("x32 sp data", out_data32, 64'h0000_0000_8000_0001);
        check("x32 sp illegal", 64'(out_illegal32), 64'd0);
        check("x32 sp to_int", 64'(out_to_int32), 64'd1);
        check("x32 sp tag", 64'(out_tag32), 64'd27);
        $display("x32 tag %0d data %h illegal %0b", out_tag32, out_data32, out_illegal32);
        tick();
        check("x32 drained", 64'(out_valid32), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
